// File: rtl/idiv_iter_param_if.sv
// Handshake/result bundle for the iterative integer divider.
// The master drives operands and control, and the slave returns the results.
interface idiv_iter_param_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RADIX_BITS = 1
);
  localparam int unsigned N  = WIDTH / RADIX_BITS;
  localparam int unsigned CW = $clog2(N + 1);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sgn;
  logic             start;
  logic             ena;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             stall;
  logic             done;
  logic             dz;
  logic [CW-1:0]    count;

  modport master (
    output a, b, sgn, start, ena,
    input  q, r, busy, stall, done, dz, count
  );

  modport slave (
    input  a, b, sgn, start, ena,
    output q, r, busy, stall, done, dz, count
  );
endinterface

// File: rtl/idiv_iter_param.sv
// Parametrised restoring integer divider retiring RADIX_BITS quotient bits per enabled cycle.
// It supports signed and unsigned operands, returns the remainder, and flags divide-by-zero.
module idiv_iter_param #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic              clk,
  input  logic              clr,
  idiv_iter_param_if.slave  bus
);
  localparam int unsigned N  = WIDTH / RADIX_BITS;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic [WIDTH-1:0] dvd, dvd_nxt;
  logic [WIDTH-1:0] dvr, dvr_nxt;
  logic             sa, sa_nxt;
  logic             sb, sb_nxt;
  logic [WIDTH-1:0] q_q, q_nxt;
  logic [WIDTH-1:0] r_q, r_nxt;
  logic             dz_q, dz_nxt;
  logic             done_q, done_nxt;
  logic             busy_q, busy_nxt;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_step, dvd_step;
  logic [WIDTH:0]   shifted, diff;

  assign a_mag = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Chained restoring steps; the WIDTH+1-bit shifted remainder cannot overflow since rem < dvr.
  always_comb begin : step
    rem_step = rem;
    dvd_step = dvd;
    shifted  = '0;
    diff     = '0;
    for (int i = 0; i < int'(RADIX_BITS); i++) begin
      shifted  = {rem_step, dvd_step[WIDTH-1]};
      diff     = shifted - {1'b0, dvr};
      dvd_step = {dvd_step[WIDTH-2:0], ~diff[WIDTH]};
      rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

  // Next-state and datapath update; the register blocks apply these only when ena is high.
  always_comb begin : fsm_next
    state_nxt = state;
    cnt_nxt   = cnt;
    rem_nxt   = rem;
    dvd_nxt   = dvd;
    dvr_nxt   = dvr;
    sa_nxt    = sa;
    sb_nxt    = sb;
    q_nxt     = q_q;
    r_nxt     = r_q;
    dz_nxt    = dz_q;
    done_nxt  = (state == DONE);

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.b == '0) begin
            q_nxt     = '1;
            r_nxt     = bus.a;
            dz_nxt    = 1'b1;
            state_nxt = DONE;
          end else begin
            dvd_nxt   = a_mag;
            dvr_nxt   = b_mag;
            rem_nxt   = '0;
            sa_nxt    = bus.sgn & bus.a[WIDTH-1];
            sb_nxt    = bus.sgn & bus.b[WIDTH-1];
            cnt_nxt   = CW'(N);
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        rem_nxt = rem_step;
        dvd_nxt = dvd_step;
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = FIX;
      end
      FIX: begin
        q_nxt     = (sa ^ sb) ? -dvd : dvd;
        r_nxt     = sa ? -rem : rem;
        dz_nxt    = 1'b0;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin : state_reg
    if (clr) begin
      state <= IDLE;
    end else if (bus.ena) begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin : data_reg
    if (clr) begin
      cnt    <= '0;
      rem    <= '0;
      dvd    <= '0;
      dvr    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      q_q    <= '0;
      r_q    <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (bus.ena) begin
      cnt    <= cnt_nxt;
      rem    <= rem_nxt;
      dvd    <= dvd_nxt;
      dvr    <= dvr_nxt;
      sa     <= sa_nxt;
      sb     <= sb_nxt;
      q_q    <= q_nxt;
      r_q    <= r_nxt;
      dz_q   <= dz_nxt;
      done_q <= done_nxt;
      busy_q <= busy_nxt;
    end
  end

  assign bus.q     = q_q;
  assign bus.r     = r_q;
  assign bus.dz    = dz_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = cnt;
  assign bus.stall = bus.start & busy_q;
endmodule

// File: tb/tb_idiv_iter_param.sv
// Directed bench for idiv_iter_param: radix-1 and radix-2 instances run the same vectors side by side.
// It also covers an ena freeze, a held start, divide-by-zero and a mid-operation clear.
module tb_idiv_iter_param;
  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  vec_t        vecs[12];
  vec_t        v;

  idiv_iter_param_if #(.WIDTH(W), .RADIX_BITS(1)) if1 ();
  idiv_iter_param_if #(.WIDTH(W), .RADIX_BITS(2)) if2 ();

  idiv_iter_param #(.WIDTH(W), .RADIX_BITS(1)) u_r1 (.clk(clk), .clr(clr), .bus(if1.slave));
  idiv_iter_param #(.WIDTH(W), .RADIX_BITS(2)) u_r2 (.clk(clk), .clr(clr), .bus(if2.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       input logic start, input logic ena);
    if1.a = a; if1.b = b; if1.sgn = sgn; if1.start = start; if1.ena = ena;
    if2.a = a; if2.b = b; if2.sgn = sgn; if2.start = start; if2.ena = ena;
  endtask

  task automatic start_op(input vec_t vv);
    @(negedge clk);
    drive(vv.a, vv.b, vv.sgn, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    if1.start = 1'b0;
    if2.start = 1'b0;
  endtask

  // Wait for both done pulses, recording latency from the accepting edge and the results.
  task automatic finish_op(input vec_t vv, input string tag, input int unsigned extra);
    int unsigned  l1 = 0, l2 = 0;
    logic [W-1:0] q1 = '0, r1 = '0, q2 = '0, r2 = '0;
    logic         dz1 = 1'b0, dz2 = 1'b0;
    for (int i = 0; i < 80 && (l1 == 0 || l2 == 0); i++) begin
      @(posedge clk);
      #1;
      if (l1 == 0 && if1.done) begin l1 = cyc - acc_cyc; q1 = if1.q; r1 = if1.r; dz1 = if1.dz; end
      if (l2 == 0 && if2.done) begin l2 = cyc - acc_cyc; q2 = if2.q; r2 = if2.r; dz2 = if2.dz; end
    end
    check({tag, " r1 latency"}, 32'(l1), vv.edz ? 32'd1 : 32'(34 + extra));
    check({tag, " r1 q"}, q1, vv.eq);
    check({tag, " r1 r"}, r1, vv.er);
    check({tag, " r1 dz"}, 32'(dz1), 32'(vv.edz));
    check({tag, " r2 latency"}, 32'(l2), vv.edz ? 32'd1 : 32'(18 + extra));
    check({tag, " r2 q"}, q2, vv.eq);
    check({tag, " r2 r"}, r2, vv.er);
    check({tag, " r2 dz"}, 32'(dz2), 32'(vv.edz));
    @(posedge clk);
    #1;
    check({tag, " r1 done pulse ends"}, 32'(if1.done), 32'd0);
    check({tag, " r1 q held"}, if1.q, vv.eq);
  endtask

  initial begin
    vecs[0]  = '{32'd568,        32'd145,        1'b0, 32'd3,          32'd133,        1'b0};
    vecs[1]  = '{32'hFFFFFFEB,   32'd8,          1'b1, 32'hFFFFFFFE,   32'hFFFFFFFB,   1'b0};
    vecs[2]  = '{32'd7,          32'd0,          1'b1, 32'hFFFFFFFF,   32'd7,          1'b1};
    vecs[3]  = '{32'd7,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd7,          1'b1};
    vecs[4]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0};
    vecs[5]  = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   1'b0};
    vecs[6]  = '{32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2,          1'b0};
    vecs[7]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[8]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[9]  = '{32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          1'b0};
    vecs[10] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          32'd0,          1'b0};
    vecs[11] = '{32'hDEADBEEF,   32'd16,         1'b0, 32'h0DEADBEE,   32'd15,         1'b0};

    // Reset state.
    clr = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    check("reset r1 q", if1.q, '0);
    check("reset r1 r", if1.r, '0);
    check("reset r1 busy", 32'(if1.busy), 32'd0);
    check("reset r1 done", 32'(if1.done), 32'd0);
    check("reset r1 dz", 32'(if1.dz), 32'd0);
    check("reset r1 count", 32'(if1.count), 32'd0);
    check("reset r2 busy", 32'(if2.busy), 32'd0);

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i]);
      finish_op(vecs[i], $sformatf("vec%0d", i), 0);
    end

    // Freeze mid-CALC with ena low while a second start is held against a busy unit.
    v = vecs[0];
    start_op(v);
    repeat (5) @(posedge clk);
    #1;
    check("freeze r1 count before", 32'(if1.count), 32'd27);
    check("freeze r2 count before", 32'(if2.count), 32'd11);
    @(negedge clk);
    drive(32'd1000, 32'd10, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("freeze r1 count", 32'(if1.count), 32'd27);
      check("freeze r2 count", 32'(if2.count), 32'd11);
      check("freeze r1 stall", 32'(if1.stall), 32'd1);
      check("freeze r2 stall", 32'(if2.stall), 32'd1);
    end
    @(negedge clk);
    if1.ena = 1'b1;
    if2.ena = 1'b1;
    @(posedge clk);
    #1;
    check("resume r1 count", 32'(if1.count), 32'd26);
    check("resume r1 stall", 32'(if1.stall), 32'd1);
    @(negedge clk);
    if1.start = 1'b0;
    if2.start = 1'b0;
    finish_op(v, "freeze", 3);

    // Clear in the middle of an operation discards it and zeroes the outputs.
    start_op(vecs[0]);
    for (int i = 0; i < 60 && if1.count != 6'd10; i++) begin
      @(posedge clk);
      #1;
    end
    check("clr r1 count reached", 32'(if1.count), 32'd10);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr r1 busy", 32'(if1.busy), 32'd0);
    check("clr r1 q", if1.q, '0);
    check("clr r1 r", if1.r, '0);
    check("clr r1 count", 32'(if1.count), 32'd0);
    check("clr r2 q", if2.q, '0);
    check("clr r2 r", if2.r, '0);

    // Recovery after clear.
    start_op(vecs[6]);
    finish_op(vecs[6], "after clr", 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
